// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit.
// Holds architectural HI/LO. The result of mult/multu/div/divu is computed
// on the start edge and parked in PendHI/PendLO. The countdown counter
// keeps Busy high for the configured latency, and the parked result
// commits to HI/LO on the edge where Busy falls.
//
// Handshake: MDOp is a request that is taken only while Busy is low.
// Start reports that a mult/multu/div/divu request is being taken this
// cycle. Requests seen while Busy is high (including mthi/mtlo) are
// dropped, not queued.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_NONE7 = 3'd7
    } md_op_e;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    md_op_e op;
    assign op = md_op_e'(MDOp);

    // Architectural and pending state.
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_valid_q, pend_valid_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    // ---------------------------------------------------------------
    // Multiplier: one 64x64 multiplier shared by mult and multu. The
    // operands are sign- or zero-extended, and the low 64 bits of the
    // product are the exact 32x32 result in either case.
    // ---------------------------------------------------------------
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    assign mul_signed = (op == OP_MULT);
    assign mul_a      = {{32{mul_signed & A[31]}}, A};
    assign mul_b      = {{32{mul_signed & B[31]}}, B};
    assign product    = mul_a * mul_b;

    // ---------------------------------------------------------------
    // Divider: one unsigned divider shared by div and divu. The signed
    // divide works on magnitudes and fixes the signs afterwards:
    // - the quotient is negative when the operand signs differ;
    // - the remainder takes the sign of the dividend.
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 / 1,
    // signs agree, so the quotient stays 0x80000000 and the remainder 0.
    // A zero divisor is replaced by 1 only to keep the datapath defined.
    // That result is never committed.
    // ---------------------------------------------------------------
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] divisor_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;

    assign div_signed   = (op == OP_DIV);
    assign a_neg        = div_signed & A[31];
    assign b_neg        = div_signed & B[31];
    assign dividend     = a_neg ? (32'd0 - A) : A;
    assign divisor      = b_neg ? (32'd0 - B) : B;
    assign div_by_zero  = (B == 32'd0);
    assign divisor_safe = div_by_zero ? 32'd1 : divisor;
    assign q_mag        = dividend / divisor_safe;
    assign r_mag        = dividend % divisor_safe;
    assign quot         = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem          = a_neg ? (32'd0 - r_mag) : r_mag;

    // A mult/multu/div/divu request is accepted this cycle.
    always_comb begin
        Start = 1'b0;
        if (!busy_q) begin
            unique case (op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: Start = 1'b1;
                default:                            Start = 1'b0;
            endcase
        end
    end

    // Next-state logic: count down while busy, otherwise accept a new op.
    always_comb begin
        hi_d         = hi_q;
        lo_d         = lo_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;

        if (busy_q) begin
            // In flight: any request on MDOp is ignored.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                cnt_d  = 4'd0;
                busy_d = 1'b0;
                if (pend_valid_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else begin
            unique case (op)
                OP_MULT, OP_MULTU: begin
                    pend_hi_d    = product[63:32];
                    pend_lo_d    = product[31:0];
                    pend_valid_d = 1'b1;
                    cnt_d        = MULT_CNT;
                    busy_d       = 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    pend_hi_d    = rem;
                    pend_lo_d    = quot;
                    pend_valid_d = !div_by_zero;
                    cnt_d        = DIV_CNT;
                    busy_d       = 1'b1;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: begin
                    // OP_NONE / OP_NONE7: hold.
                end
            endcase
        end
    end

    // State registers with synchronous reset. Reset also discards any
    // in-flight result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            pend_hi_q    <= 32'd0;
            pend_lo_q    <= 32'd0;
            pend_valid_q <= 1'b0;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b0;
        end else begin
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
